// File: rtl/csr_pkg.sv
// Shared CSR bus payload types and field widths.
package csr_pkg;

    localparam int unsigned CSR_SELECT_W = 16;
    localparam int unsigned CSR_ADDR_W   = 16;
    localparam int unsigned CSR_DATA_W   = 32;

    typedef struct packed {
        logic                    valid;
        logic                    read_not_write;
        logic [CSR_SELECT_W-1:0] select;
        logic [CSR_ADDR_W-1:0]   address;
        logic [CSR_DATA_W-1:0]   data;
    } csr_request_t;

    typedef struct packed {
        logic                  acknowledge;
        logic                  read_data_valid;
        logic                  read_data_error;
        logic [CSR_DATA_W-1:0] read_data;
    } csr_response_t;

endpackage

// File: rtl/csr_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping modulo N.
module csr_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_c_o,
    output logic [PTR_W-1:0] idx_c_o,
    output logic             any_c_o
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        grant_c_o = '0;
        idx_c_o   = '0;
        any_c_o   = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = PTR_W'((32'(ptr_i) + k) % N);
            if (!any_c_o && req_i[cand]) begin
                any_c_o         = 1'b1;
                idx_c_o         = cand;
                grant_c_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csr_master_arbiter.sv
// Shares one CSR master port between NUM_CLIENTS requesters with round-robin
// arbitration; sequences request, acknowledge, optional read data, and completion.
module csr_master_arbiter
    import csr_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_CLIENTS-1:0]              client_req,
    input  logic [NUM_CLIENTS-1:0]              client_read_not_write,
    input  logic [CSR_SELECT_W*NUM_CLIENTS-1:0] client_select,
    input  logic [CSR_ADDR_W*NUM_CLIENTS-1:0]   client_address,
    input  logic [CSR_DATA_W*NUM_CLIENTS-1:0]   client_wdata,
    output logic [NUM_CLIENTS-1:0]              client_done,
    output logic [CSR_DATA_W-1:0]               client_read_data,
    output logic                                client_error,
    output logic                                csr_request__valid,
    output logic                                csr_request__read_not_write,
    output logic [CSR_SELECT_W-1:0]             csr_request__select,
    output logic [CSR_ADDR_W-1:0]               csr_request__address,
    output logic [CSR_DATA_W-1:0]               csr_request__data,
    input  logic                                csr_response__acknowledge,
    input  logic                                csr_response__read_data_valid,
    input  logic                                csr_response__read_data_error,
    input  logic [CSR_DATA_W-1:0]               csr_response__read_data
);

    localparam int unsigned N     = NUM_CLIENTS;
    localparam int unsigned PTR_W = $clog2(NUM_CLIENTS);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDATA, S_DONE} state_e;

    state_e                state_q;
    logic [PTR_W-1:0]      ptr_q, ptr_d, grant_q;
    logic [N-1:0]          grant_oh_q;
    csr_request_t          req_q, req_d;
    csr_response_t         rsp;
    logic [N-1:0]          done_q;
    logic [CSR_DATA_W-1:0] rdata_q;
    logic                  err_q;

    logic [N-1:0]          arb_grant;
    logic [PTR_W-1:0]      arb_idx;
    logic                  arb_any;

    logic [CSR_SELECT_W-1:0] sel_a   [N];
    logic [CSR_ADDR_W-1:0]   addr_a  [N];
    logic [CSR_DATA_W-1:0]   wdata_a [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign sel_a[g]   = client_select[g*CSR_SELECT_W +: CSR_SELECT_W];
        assign addr_a[g]  = client_address[g*CSR_ADDR_W +: CSR_ADDR_W];
        assign wdata_a[g] = client_wdata[g*CSR_DATA_W +: CSR_DATA_W];
    end

    assign rsp = '{acknowledge:     csr_response__acknowledge,
                   read_data_valid: csr_response__read_data_valid,
                   read_data_error: csr_response__read_data_error,
                   read_data:       csr_response__read_data};

    csr_rr_arbiter #(.N(N), .PTR_W(PTR_W)) u_rr (
        .req_i     (client_req),
        .ptr_i     (ptr_q),
        .grant_c_o (arb_grant),
        .idx_c_o   (arb_idx),
        .any_c_o   (arb_any)
    );

    // Winner's request as it will be launched on grant.
    always_comb begin
        req_d                = '0;
        req_d.valid          = 1'b1;
        req_d.read_not_write = client_read_not_write[arb_idx];
        req_d.select         = sel_a[arb_idx];
        req_d.address        = addr_a[arb_idx];
        req_d.data           = wdata_a[arb_idx];
    end

    always_comb begin
        ptr_d = (grant_q == PTR_W'(N - 1)) ? '0 : grant_q + 1'b1;
    end

    // Transaction sequencer; every output comes straight from a register here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            grant_oh_q <= '0;
            req_q      <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arb_any) begin
                        req_q      <= req_d;
                        grant_q    <= arb_idx;
                        grant_oh_q <= arb_grant;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (rsp.acknowledge) begin
                        req_q.valid <= 1'b0;
                        if (req_q.read_not_write) begin
                            state_q <= S_RDATA;
                        end else begin
                            done_q  <= grant_oh_q;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RDATA: begin
                    if (rsp.read_data_valid) begin
                        rdata_q <= rsp.read_data;
                        err_q   <= rsp.read_data_error;
                        done_q  <= grant_oh_q;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= '0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    ptr_q   <= ptr_d;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign client_done                 = done_q;
    assign client_read_data            = rdata_q;
    assign client_error                = err_q;
    assign csr_request__valid          = req_q.valid;
    assign csr_request__read_not_write = req_q.read_not_write;
    assign csr_request__select         = req_q.select;
    assign csr_request__address        = req_q.address;
    assign csr_request__data           = req_q.data;

endmodule

// File: tb/tb_csr_master_arbiter.sv
// Bench for csr_master_arbiter: CSR target + timeout target model, transaction-level
// reference model compared every cycle, directed scenarios and a randomized phase.
module tb_csr_master_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0]    client_req = '0;
    logic [N-1:0]    client_rnw = '0;
    logic [16*N-1:0] client_select;
    logic [16*N-1:0] client_address;
    logic [32*N-1:0] client_wdata;
    logic [N-1:0]    client_done;
    logic [31:0]     client_read_data;
    logic            client_error;
    logic            csr_request__valid, csr_request__read_not_write;
    logic [15:0]     csr_request__select, csr_request__address;
    logic [31:0]     csr_request__data;
    logic            ack = 1'b0, rdv = 1'b0, rerr = 1'b0;
    logic [31:0]     rdata = '0;

    logic [15:0] b_sel [N];
    logic [15:0] b_adr [N];
    logic [31:0] b_wd  [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign client_select[g*16 +: 16]  = b_sel[g];
        assign client_address[g*16 +: 16] = b_adr[g];
        assign client_wdata[g*32 +: 32]   = b_wd[g];
    end

    csr_master_arbiter #(.NUM_CLIENTS(N)) dut (
        .clk                           (clk),
        .reset_n                       (reset_n),
        .client_req                    (client_req),
        .client_read_not_write         (client_rnw),
        .client_select                 (client_select),
        .client_address                (client_address),
        .client_wdata                  (client_wdata),
        .client_done                   (client_done),
        .client_read_data              (client_read_data),
        .client_error                  (client_error),
        .csr_request__valid            (csr_request__valid),
        .csr_request__read_not_write   (csr_request__read_not_write),
        .csr_request__select           (csr_request__select),
        .csr_request__address          (csr_request__address),
        .csr_request__data             (csr_request__data),
        .csr_response__acknowledge     (ack),
        .csr_response__read_data_valid (rdv),
        .csr_response__read_data_error (rerr),
        .csr_response__read_data       (rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // CSR target: programmable ack / read-data delay; select 0xFFFF goes to the timeout target.
    int ts = 0, cnt = 0, adly = 0, rdly = 0;
    int fa = -1, fr = -1;
    bit t_to = 1'b0, rnw_t = 1'b0;
    bit f_data_en = 1'b0;
    logic [31:0] f_data = '0;

    always @(negedge clk) begin
        ack = 1'b0; rdv = 1'b0; rerr = 1'b0; rdata = '0;
        if (!reset_n) begin
            ts = 0;
        end else begin
            if (ts == 0 && csr_request__valid) begin
                ts    = 1;
                cnt   = 0;
                rnw_t = csr_request__read_not_write;
                t_to  = (csr_request__select == 16'hFFFF);
                adly  = t_to ? 5 : (fa >= 0 ? fa : int'($urandom_range(0, 4)));
                rdly  = t_to ? 0 : (fr >= 0 ? fr : int'($urandom_range(0, 3)));
            end
            if (ts == 1) begin
                if (cnt == adly) begin
                    ack = 1'b1;
                    ts  = rnw_t ? 2 : 0;
                    cnt = 0;
                end else cnt++;
            end else if (ts == 2) begin
                if (cnt == rdly) begin
                    rdv   = 1'b1;
                    rerr  = t_to;
                    rdata = t_to ? 32'h0 : (f_data_en ? f_data : $urandom());
                    ts    = 0;
                end else cnt++;
            end
        end
    end

    // Reference model: one transaction at a time, round-robin from a pointer.
    int          m_stage = 0;
    int          m_ptr   = 0;
    int          m_win   = 0;
    logic        e_valid = 1'b0, e_rnw = 1'b0, e_err = 1'b0;
    logic [15:0] e_sel = '0, e_adr = '0;
    logic [31:0] e_dat = '0, e_rd = '0;
    logic [N-1:0] e_done = '0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (r[2'(c)]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_stage = 0; m_ptr = 0; e_valid = 0; e_rnw = 0; e_sel = '0; e_adr = '0;
            e_dat = '0; e_done = '0; e_rd = '0; e_err = 0;
        end else begin
            case (m_stage)
                0: if (|client_req) begin
                    m_win   = pick(client_req, m_ptr);
                    e_valid = 1'b1;
                    e_rnw   = client_rnw[2'(m_win)];
                    e_sel   = b_sel[2'(m_win)];
                    e_adr   = b_adr[2'(m_win)];
                    e_dat   = b_wd[2'(m_win)];
                    m_stage = 1;
                end
                1: if (ack) begin
                    e_valid = 1'b0;
                    if (e_rnw) m_stage = 2;
                    else begin e_done = N'(1) << m_win; m_stage = 3; end
                end
                2: if (rdv) begin
                    e_rd = rdata; e_err = rerr; e_done = N'(1) << m_win; m_stage = 3;
                end
                default: begin
                    e_done = '0; e_rd = '0; e_err = 1'b0;
                    m_ptr = (m_win + 1) % N; m_stage = 0;
                end
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("valid", 64'(csr_request__valid), 64'(e_valid));
            if (e_valid) begin
                chk("req_sel_addr", 64'({csr_request__select, csr_request__address}), 64'({e_sel, e_adr}));
                chk("req_rnw_data", 64'({csr_request__read_not_write, csr_request__data}), 64'({e_rnw, e_dat}));
            end
            chk("done", 64'(client_done), 64'(e_done));
            chk("rdata_err", 64'({client_error, client_read_data}), 64'({e_err, e_rd}));
        end
    end

    function automatic int oh2idx(input logic [N-1:0] d);
        for (int i = 0; i < N; i++) if (d[2'(i)]) return i;
        return -1;
    endfunction

    task automatic wait_done(input int budget, output logic [N-1:0] d, output int cycles);
        d = '0;
        cycles = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (|client_done) begin
                d = client_done;
                return;
            end
        end
        n_checks++;
        $display("FAIL wait_done: no client_done within %0d cycles at %0t", budget, $time);
    endtask

    task automatic set_client(input int i, input logic rnw, input logic [15:0] s,
                              input logic [15:0] a, input logic [31:0] w);
        client_rnw[2'(i)] = rnw;
        b_sel[2'(i)] = s;
        b_adr[2'(i)] = a;
        b_wd[2'(i)]  = w;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] d;
        int cy;
        int n_rand_done;
        for (int i = 0; i < N; i++) set_client(i, 1'b0, '0, '0, '0);

        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(csr_request__valid), 64'(0));
        chk("rst_done", 64'(client_done), 64'(0));
        chk("rst_rdata_err", 64'({client_error, client_read_data}), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Single write from client 2, ack after 2 cycles.
        fa = 2;
        set_client(2, 1'b0, 16'h0003, 16'h0010, 32'hDEADBEEF);
        client_req[2] = 1'b1;
        @(negedge clk);
        chk("t1_valid", 64'(csr_request__valid), 64'(1));
        chk("t1_fields", 64'({csr_request__select, csr_request__address, csr_request__data}),
            64'({16'h0003, 16'h0010, 32'hDEADBEEF}));
        wait_done(40, d, cy);
        client_req = client_req & ~d;
        chk("t1_done", 64'(d), 64'(4'b0100));
        chk("t1_latency", 64'(cy), 64'(3));
        chk("t1_valid_low", 64'(csr_request__valid), 64'(0));

        // Single read from client 0, data one cycle after ack.
        fa = 1; fr = 0; f_data_en = 1'b1; f_data = 32'h12345678;
        set_client(0, 1'b1, 16'h0001, 16'h0020, 32'h0);
        client_req[0] = 1'b1;
        wait_done(40, d, cy);
        client_req = client_req & ~d;
        chk("t2_done", 64'(d), 64'(4'b0001));
        chk("t2_rdata_err", 64'({client_error, client_read_data}), 64'({1'b0, 32'h12345678}));
        f_data_en = 1'b0; fr = -1;

        // All four clients continuously, pointer 0 after a fresh reset.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        fa = 0;
        for (int i = 0; i < N; i++) set_client(i, 1'b0, 16'(i + 1), 16'(i * 4), $urandom());
        client_req = '1;
        for (int k = 0; k < 20; k++) begin
            wait_done(40, d, cy);
            chk("t3_order", 64'(oh2idx(d)), 64'(k % 4));
        end
        client_req = '0;
        fa = -1;

        // Read to an undecoded select: timeout target answers with an error.
        set_client(3, 1'b1, 16'hFFFF, 16'h0040, 32'h0);
        client_req[3] = 1'b1;
        wait_done(40, d, cy);
        client_req = client_req & ~d;
        chk("t4_done", 64'(d), 64'(4'b1000));
        chk("t4_err_data", 64'({client_error, client_read_data}), 64'({1'b1, 32'h0}));

        // Client 1 drops its request two cycles after grant; it must still complete.
        fa = 4;
        set_client(1, 1'b0, 16'h0002, 16'h0050, 32'hA5A5A5A5);
        client_req[1] = 1'b1;
        repeat (2) @(negedge clk);
        client_req[1] = 1'b0;
        wait_done(40, d, cy);
        chk("t5_done", 64'(d), 64'(4'b0010));
        fa = 0;
        client_req = '1;
        wait_done(40, d, cy);
        client_req = '0;
        chk("t5_next_ptr", 64'(d), 64'(4'b0100));
        fa = -1;

        // Reset while waiting for read data.
        fa = 0; fr = 6;
        set_client(3, 1'b1, 16'h0005, 16'h0060, 32'h0);
        client_req[3] = 1'b1;
        cy = 0;
        while (!(ts == 2 && cnt >= 2) && cy < 40) begin
            @(negedge clk);
            cy++;
        end
        chk("t6_reached_rdata", 64'(ts == 2), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_zero", 64'({csr_request__valid, csr_request__read_not_write, client_done,
                                  client_error, csr_request__select, csr_request__address}), 64'(0));
        chk("t6_async_zero_data", 64'({client_read_data, csr_request__data}), 64'(0));
        client_req = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        fa = -1; fr = -1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_no_done", 64'(client_done), 64'(0));
        end
        set_client(1, 1'b0, 16'h0007, 16'h0070, 32'h1);
        set_client(2, 1'b0, 16'h0008, 16'h0080, 32'h2);
        client_req = 4'b0110;
        wait_done(40, d, cy);
        client_req = client_req & ~d;
        chk("t6_first_grant", 64'(d), 64'(4'b0010));
        wait_done(40, d, cy);
        client_req = '0;

        // Randomized traffic checked by the model every cycle.
        n_rand_done = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (client_done[2'(i)]) begin
                    client_req[2'(i)] = 1'b0;
                    n_rand_done++;
                end else if (!client_req[2'(i)]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_client(i, 1'($urandom()),
                                   ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE)),
                                   16'($urandom()), $urandom());
                        client_req[2'(i)] = 1'b1;
                    end
                end else begin
                    if ($urandom_range(0, 63) == 0) client_req[2'(i)] = 1'b0;
                    if ($urandom_range(0, 7) == 0) set_client(i, 1'($urandom()), 16'($urandom_range(0, 16'hFFFE)),
                                                              16'($urandom()), $urandom());
                end
            end
        end
        client_req = '0;
        repeat (30) @(negedge clk);
        chk("rand_activity", 64'(n_rand_done > 20), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
